// File: rtl/eth_tx_multi_rate_limit_if.sv
// ----------------------------------------------------------------------------
// eth_tx_multi_rate_limit_if
// Per-channel stream signals watched by the TX rate limiter, one bit per
// channel (bit c = channel c).
//   valid     : source has a beat on channel c
//   ready     : sink accepts a beat on channel c
//   eop       : the beat on channel c is the last of its packet
//   tx_enable : limiter permission for the source to start a new packet
// Modports:
//   master : source/sink side (drives valid/ready/eop, sees tx_enable)
//   slave  : limiter side (observes valid/ready/eop, drives tx_enable)
// ----------------------------------------------------------------------------
interface eth_tx_multi_rate_limit_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] ready;
    logic [NUM_CH-1:0] eop;
    logic [NUM_CH-1:0] tx_enable;

    modport master (output valid, output ready, output eop, input tx_enable);
    modport slave  (input valid, input ready, input eop, output tx_enable);
endinterface

// File: rtl/eth_tx_multi_rate_limit.sv
// ----------------------------------------------------------------------------
// eth_tx_multi_rate_limit
// Per-channel token-bucket TX rate limiter. Each started channel earns
// RATE_ADD credits per cycle and pays BEAT_COST per accepted beat. When a
// packet ends with the bucket going negative, the channel's tx_enable drops
// until the bucket has recovered to >= 0. Beats are only observed, never
// gated, so packets are never split.
// Ports:
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_start        : per-channel start (level or pulse), latched until reset
//   stream         : valid/ready/eop in, tx_enable out (slave modport)
//   i_rate_add     : credits earned per cycle, channel c at [c*RATE_W +: RATE_W]
//   i_beat_cost    : credits spent per accepted beat, same packing
//   i_clr_stall    : per-channel pulse clearing the stall counter
//   o_credit       : registered signed bucket per channel (debug)
//   o_stall_cnt    : cycles spent with tx_enable low since the last clear
// ----------------------------------------------------------------------------
module eth_tx_multi_rate_limit #(
    parameter int NUM_CH    = 4,
    parameter int RATE_W    = 8,
    parameter int CREDIT_W  = 14,
    parameter int BURST_CAP = 256,
    parameter int STALL_W   = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NUM_CH-1:0]            i_start,
    eth_tx_multi_rate_limit_if.slave     stream,
    input  logic [NUM_CH*RATE_W-1:0]     i_rate_add,
    input  logic [NUM_CH*RATE_W-1:0]     i_beat_cost,
    input  logic [NUM_CH-1:0]            i_clr_stall,
    output logic [NUM_CH*CREDIT_W-1:0]   o_credit,
    output logic [NUM_CH*STALL_W-1:0]    o_stall_cnt
);

    // Two guard bits cover bucket + add - cost before saturation.
    localparam int SUM_W = CREDIT_W + 2;
    localparam logic signed [SUM_W-1:0] CAP_HI = SUM_W'(BURST_CAP);
    // Most negative CREDIT_W value, sign-extended to SUM_W.
    localparam logic signed [SUM_W-1:0] CAP_LO =
        {{(SUM_W-CREDIT_W+1){1'b1}}, {(CREDIT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e                     state_q  [NUM_CH];
    state_e                     state_d  [NUM_CH];
    logic signed [CREDIT_W-1:0] bucket_q [NUM_CH];
    logic signed [CREDIT_W-1:0] bucket_d [NUM_CH];
    logic [STALL_W-1:0]         stall_q  [NUM_CH];
    logic [STALL_W-1:0]         stall_d  [NUM_CH];

    logic [NUM_CH-1:0] xfer;
    logic [NUM_CH-1:0] eop_xfer;

    assign xfer     = stream.valid & stream.ready;
    assign eop_xfer = xfer & stream.eop;

    function automatic logic signed [CREDIT_W-1:0] sat_bucket(
        input logic signed [SUM_W-1:0] s
    );
        logic signed [CREDIT_W-1:0] r;
        if (s > CAP_HI) begin
            r = CREDIT_W'(CAP_HI);
        end else if (s < CAP_LO) begin
            r = CREDIT_W'(CAP_LO);
        end else begin
            r = CREDIT_W'(s);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Datapath next state: bucket and stall counter per channel.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        for (int c = 0; c < NUM_CH; c++) begin
            logic signed [SUM_W-1:0] b_ext;
            logic signed [SUM_W-1:0] add_ext;
            logic signed [SUM_W-1:0] cost_ext;
            b_ext    = {{(SUM_W-CREDIT_W){bucket_q[c][CREDIT_W-1]}}, bucket_q[c]};
            add_ext  = '0;
            cost_ext = '0;
            // Credit accrues only once the channel has been started.
            if (state_q[c] != ST_IDLE) begin
                add_ext = $signed({{(SUM_W-RATE_W){1'b0}}, i_rate_add[c*RATE_W +: RATE_W]});
            end
            // Any accepted beat debits, including beats before start.
            if (xfer[c]) begin
                cost_ext = $signed({{(SUM_W-RATE_W){1'b0}}, i_beat_cost[c*RATE_W +: RATE_W]});
            end
            bucket_d[c] = sat_bucket(b_ext + add_ext - cost_ext);

            stall_d[c] = stall_q[c];
            if (i_clr_stall[c]) begin
                stall_d[c] = '0;
            end else if (state_q[c] == ST_HOLD && stall_q[c] != '1) begin
                stall_d[c] = stall_q[c] + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state. Decisions look at the post-update bucket so enable
    // follows the bucket with no extra idle cycle.
    // ------------------------------------------------------------------
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            unique case (state_q[c])
                ST_IDLE: if (i_start[c])                                  state_d[c] = ST_RUN;
                ST_RUN:  if (eop_xfer[c] && bucket_d[c][CREDIT_W-1])      state_d[c] = ST_HOLD;
                ST_HOLD: if (!bucket_d[c][CREDIT_W-1])                    state_d[c] = ST_RUN;
                default:                                                  state_d[c] = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= ST_IDLE;
                bucket_q[c] <= '0;
                stall_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= state_d[c];
                bucket_q[c] <= bucket_d[c];
                stall_q[c]  <= stall_d[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: Moore enable plus flattened debug buses.
    // ------------------------------------------------------------------
    always_comb begin
        stream.tx_enable = '1;
        o_credit         = '0;
        o_stall_cnt      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            stream.tx_enable[c]               = (state_q[c] != ST_HOLD);
            o_credit[c*CREDIT_W +: CREDIT_W]  = bucket_q[c];
            o_stall_cnt[c*STALL_W +: STALL_W] = stall_q[c];
        end
    end

endmodule

// File: tb/tb_eth_tx_multi_rate_limit.sv
// ----------------------------------------------------------------------------
// tb_eth_tx_multi_rate_limit
// Random and directed traffic on four channels. A token-bucket reference
// model (plain integers) predicts enable, credit and stall count for every
// cycle; predictions are queued and a separate monitor compares them with
// the DUT one step after each rising edge.
// ----------------------------------------------------------------------------
module tb_eth_tx_multi_rate_limit;

    localparam int NUM_CH    = 4;
    localparam int RATE_W    = 8;
    localparam int CREDIT_W  = 14;
    localparam int BURST_CAP = 256;
    localparam int STALL_W   = 32;
    localparam int CREDIT_MIN = -(2 ** (CREDIT_W - 1));
    localparam longint STALL_MAX = (64'd1 << STALL_W) - 1;

    typedef enum int {M_OFF, M_FULL, M_RAND} mode_e;

    typedef struct packed {
        logic [NUM_CH-1:0]               en;
        logic [NUM_CH-1:0][CREDIT_W-1:0] credit;
        logic [NUM_CH-1:0][STALL_W-1:0]  stall;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst       = 1'b1;
    logic [NUM_CH-1:0]           start     = '0;
    logic [NUM_CH-1:0]           clr       = '0;
    logic [NUM_CH*RATE_W-1:0]    rate_add  = '0;
    logic [NUM_CH*RATE_W-1:0]    beat_cost = '0;
    logic [NUM_CH*CREDIT_W-1:0]  credit;
    logic [NUM_CH*STALL_W-1:0]   stall_cnt;

    eth_tx_multi_rate_limit_if #(.NUM_CH(NUM_CH)) bus ();

    eth_tx_multi_rate_limit #(
        .NUM_CH(NUM_CH), .RATE_W(RATE_W), .CREDIT_W(CREDIT_W),
        .BURST_CAP(BURST_CAP), .STALL_W(STALL_W)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .stream      (bus.slave),
        .i_rate_add  (rate_add),
        .i_beat_cost (beat_cost),
        .i_clr_stall (clr),
        .o_credit    (credit),
        .o_stall_cnt (stall_cnt)
    );

    // Inputs requested for the next cycle; applied just after a falling edge.
    logic              nxt_rst   = 1'b1;
    logic [NUM_CH-1:0] nxt_start = '0;
    logic [NUM_CH-1:0] nxt_clr   = '0;
    logic [RATE_W-1:0] nxt_add  [NUM_CH];
    logic [RATE_W-1:0] nxt_cost [NUM_CH];
    mode_e             mode     [NUM_CH];
    int                pkt_len  [NUM_CH];

    // Source state.
    bit in_pkt [NUM_CH];
    int left   [NUM_CH];

    // Reference model.
    int     m_credit  [NUM_CH];
    bit     m_started [NUM_CH];
    bit     m_gated   [NUM_CH];
    longint m_stall   [NUM_CH];

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   count_en = 1'b0;
    int   beats0   = 0;

    task automatic check(input string name, input int ch,
                         input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ch%0d: got %0d expected %0d (t=%0t)", name, ch, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus model update.
    task automatic cycle();
        logic [NUM_CH-1:0] v, r, e;
        exp_t ex;
        @(negedge clk);
        rst   = nxt_rst;
        start = nxt_start;
        clr   = nxt_clr;
        for (int c = 0; c < NUM_CH; c++) begin
            rate_add[c*RATE_W +: RATE_W]  = nxt_add[c];
            beat_cost[c*RATE_W +: RATE_W] = nxt_cost[c];
        end
        v = '0; r = '0; e = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mode[c] != M_OFF) begin
                // New packets only start while the limiter allows it.
                if (!in_pkt[c] && bus.tx_enable[c] === 1'b1 &&
                    (mode[c] == M_FULL || $urandom_range(0, 3) == 0)) begin
                    in_pkt[c] = 1'b1;
                    left[c]   = (pkt_len[c] != 0) ? pkt_len[c] : int'($urandom_range(1, 8));
                end
                if (in_pkt[c]) begin
                    v[c] = (mode[c] == M_FULL) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    r[c] = (mode[c] == M_FULL) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    e[c] = (left[c] == 1);
                end
            end else begin
                r[c] = 1'($urandom_range(0, 1));
            end
        end
        bus.valid = v;
        bus.ready = r;
        bus.eop   = e;

        for (int c = 0; c < NUM_CH; c++) begin
            bit xf;
            int nxt;
            xf = v[c] & r[c];
            if (rst) begin
                m_credit[c]  = 0;
                m_started[c] = 1'b0;
                m_gated[c]   = 1'b0;
                m_stall[c]   = 0;
            end else begin
                nxt = m_credit[c] + (m_started[c] ? int'(nxt_add[c]) : 0)
                                  - (xf ? int'(nxt_cost[c]) : 0);
                if (nxt > BURST_CAP)  nxt = BURST_CAP;
                if (nxt < CREDIT_MIN) nxt = CREDIT_MIN;
                if (clr[c])                                 m_stall[c] = 0;
                else if (m_gated[c] && m_stall[c] != STALL_MAX) m_stall[c]++;
                // A started channel is blocked after a packet that leaves it
                // in debt, and released once credit is non-negative again.
                if (!m_started[c])   m_gated[c] = 1'b0;
                else if (m_gated[c]) m_gated[c] = (nxt < 0);
                else                 m_gated[c] = xf && e[c] && (nxt < 0);
                m_started[c] = m_started[c] | start[c];
                m_credit[c]  = nxt;
            end
            if (xf) begin
                left[c]--;
                if (left[c] == 0) in_pkt[c] = 1'b0;
                if (count_en && c == 0) beats0++;
            end
            ex.en[c]     = !m_gated[c];
            ex.credit[c] = CREDIT_W'(m_credit[c]);
            ex.stall[c]  = STALL_W'(m_stall[c]);
        end
        exp_q.push_back(ex);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset(input int n);
        nxt_rst = 1'b1;
        run(n);
        nxt_rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) mode[c] = M_OFF;
    endtask

    task automatic pulse_start(input logic [NUM_CH-1:0] m);
        nxt_start = m;
        run(1);
        nxt_start = '0;
    endtask

    // Monitor: compares each queued prediction just after the edge it refers to.
    initial begin
        exp_t e;
        logic signed [63:0] act_c, exp_c;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int c = 0; c < NUM_CH; c++) begin
                    check("tx_enable", c, 64'(bus.tx_enable[c]), 64'(e.en[c]));
                    act_c = $signed(credit[c*CREDIT_W +: CREDIT_W]);
                    exp_c = $signed(e.credit[c]);
                    check("credit", c, act_c, exp_c);
                    check("stall_cnt", c, 64'(stall_cnt[c*STALL_W +: STALL_W]), 64'(e.stall[c]));
                end
            end
        end
    end

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            nxt_add[c] = '0; nxt_cost[c] = '0; mode[c] = M_OFF; pkt_len[c] = 1;
            in_pkt[c] = 1'b0; left[c] = 0;
            m_credit[c] = 0; m_started[c] = 1'b0; m_gated[c] = 1'b0; m_stall[c] = 0;
        end
        bus.valid = '0; bus.ready = '0; bus.eop = '0;

        // Reset state.
        do_reset(3);

        // T1: 10/13 on ch0 with 1-beat packets for 13000 cycles.
        nxt_add[0] = 8'd10; nxt_cost[0] = 8'd13; pkt_len[0] = 1;
        pulse_start(4'b0001);
        mode[0] = M_FULL;
        beats0 = 0; count_en = 1'b1;
        run(13000);
        count_en = 1'b0;
        check("t1_beats_within_10000_pm1", 0, 64'(beats0 >= 9999 && beats0 <= 10001), 64'd1);
        mode[0] = M_OFF;

        // T2: 40-beat packets on ch1, never gated mid-packet.
        do_reset(2);
        nxt_add[1] = 8'd10; nxt_cost[1] = 8'd13; pkt_len[1] = 40;
        pulse_start(4'b0010);
        mode[1] = M_FULL;
        run(400);

        // Negative saturation: heavy traffic before start on ch0.
        do_reset(2);
        nxt_add[0] = 8'd0; nxt_cost[0] = 8'd255; pkt_len[0] = 1;
        mode[0] = M_FULL;
        run(60);

        // T3: idle bank saturates at BURST_CAP, then full-rate burst.
        do_reset(2);
        nxt_add[2] = 8'd10; nxt_cost[2] = 8'd13; pkt_len[2] = 4;
        pulse_start(4'b0100);
        run(1000);
        mode[2] = M_FULL;
        run(600);

        // T4: add == cost never gates.
        do_reset(2);
        nxt_add[3] = 8'd13; nxt_cost[3] = 8'd13; pkt_len[3] = 3;
        pulse_start(4'b1000);
        mode[3] = M_FULL;
        run(2000);

        // T5: reset while ch0 is held.
        do_reset(2);
        nxt_add[0] = 8'd2; nxt_cost[0] = 8'd13; pkt_len[0] = 1;
        pulse_start(4'b0001);
        mode[0] = M_FULL;
        run(40);
        nxt_rst = 1'b1;
        run(1);
        nxt_rst = 1'b0;
        run(40);

        // T6: four channels at different rates, then clear one stall counter.
        do_reset(2);
        nxt_add[0] = 8'd5; nxt_add[1] = 8'd10; nxt_add[2] = 8'd12; nxt_add[3] = 8'd13;
        for (int c = 0; c < NUM_CH; c++) begin
            nxt_cost[c] = 8'd13; pkt_len[c] = 1; mode[c] = M_FULL;
        end
        pulse_start(4'b1111);
        run(4000);
        nxt_clr = 4'b0001;
        run(1);
        nxt_clr = '0;
        run(20);

        // Random mix: rates, costs, modes, starts, clears and resets.
        repeat (200) begin
            for (int c = 0; c < NUM_CH; c++) begin
                nxt_add[c]  = 8'($urandom_range(0, 40));
                nxt_cost[c] = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(1, 40));
                mode[c]     = mode_e'($urandom_range(0, 2));
                pkt_len[c]  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
            end
            nxt_start = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            nxt_clr   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : '0;
            nxt_rst   = ($urandom_range(0, 49) == 0);
            run(1);
            nxt_start = '0; nxt_clr = '0; nxt_rst = 1'b0;
            run(int'($urandom_range(50, 150)));
        end

        for (int c = 0; c < NUM_CH; c++) mode[c] = M_OFF;
        run(2);
        @(posedge clk);
        #2;
        check("queue_drained", 0, 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
